inst_fetch: RTL and testbench

Instruction-fetch stage between the PC register and decode. Takes the current PC, issues pipelined read requests on the SRAM-like instruction bus, and advances the PC register through its enable on every accepted request. Returned instructions are buffered in an in-order queue and presented to ID with a valid/ready handshake. A flush from later stages drops queued entries and discards late bus responses.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_queue.sv | 73 +++++++
 rtl/inst_fetch.sv | 121 ++++++++++++
 tb/tb_inst_fetch.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Core-wide types and constants shared by the fetch stage and its helpers.
package cpu_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic RST_ACTIVE = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              adel;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of arbitrary element type with clear. Push into a full
// queue is accepted only when a pop happens in the same cycle.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output T                       head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is reset too so the head reads as zero straight out of reset.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: credit-limited pipelined bus requests, in-order entry
// queue towards decode, and discard accounting for responses orphaned by flush.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_en,
    input  logic              flush,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [INST_W-1:0] inst_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_adel
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [CW-1:0]     entry_count;
    logic [CW-1:0]     pc_count;
    logic [CW:0]       credit_sum;
    logic [ADDR_W-1:0] pc_head;
    fetch_entry_t      entry_head;
    fetch_entry_t      push_entry;
    logic              can_issue, aligned, accept, adel_push;
    logic              resp_live, resp_drop, entry_push, entry_pop;

    always_comb begin
        credit_sum = {1'b0, entry_count} + {1'b0, outstanding_q};
        can_issue  = (rst != RST_ACTIVE) && !flush && (credit_sum < {1'b0, DEPTH_C});
        aligned    = (pc[1:0] == 2'b00);
        inst_req   = aligned && can_issue;
        inst_addr  = pc;
        accept     = inst_req && inst_addr_ok;
        // A misaligned PC waits for the bus to drain so the error entry stays in order.
        adel_push  = !aligned && can_issue && (outstanding_q == '0);
        pc_en      = accept || adel_push;

        resp_drop  = inst_data_ok && (discard_q != '0);
        resp_live  = inst_data_ok && (discard_q == '0) && (outstanding_q != '0) && !flush;
        entry_push = resp_live || adel_push;
        entry_pop  = if_valid && if_ready;

        if (resp_live) begin
            push_entry = '{pc: pc_head, inst: inst_rdata, adel: 1'b0};
        end else begin
            push_entry = '{pc: pc, inst: {INST_W{1'b0}}, adel: 1'b1};
        end

        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (flush) begin
            // Every in-flight request becomes a discard, minus a response landing now.
            outstanding_d = '0;
            discard_d     = discard_q + outstanding_q
                          - CW'(inst_data_ok && ((discard_q != '0) || (outstanding_q != '0)));
        end else begin
            outstanding_d = outstanding_q + CW'(accept) - CW'(resp_live);
            discard_d     = discard_q - CW'(resp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_entry_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (entry_push),
        .push_data (push_entry),
        .pop       (entry_pop),
        .count     (entry_count),
        .head      (entry_head)
    );

    fetch_queue #(
        .DEPTH (DEPTH),
        .T     (logic [ADDR_W-1:0])
    ) u_pc_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (accept),
        .push_data (pc),
        .pop       (resp_live),
        .count     (pc_count),
        .head      (pc_head)
    );

    assign if_valid = (entry_count != '0);
    assign if_pc    = entry_head.pc;
    assign if_inst  = entry_head.inst;
    assign if_adel  = entry_head.adel;

    a_outstanding_bound: assert property (@(posedge clk) disable iff (rst) outstanding_q <= DEPTH_C);
    a_discard_bound:     assert property (@(posedge clk) disable iff (rst) discard_q <= DEPTH_C);
    a_pc_fifo_tracks:    assert property (@(posedge clk) disable iff (rst) pc_count == outstanding_q);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a simple in-order bus responder.
module tb_inst_fetch;

    localparam logic [31:0] BASE = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_en;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    int checks   = 0;
    int failures = 0;

    logic [31:0] bus_q[$];
    logic [31:0] cur_pc;

    logic        o_req, o_pcen, o_pop, o_adel;
    logic [31:0] o_pc, o_inst;

    inst_fetch #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .pc_en        (pc_en),
        .flush        (flush),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_adel      (if_adel)
    );

    always #5 clk = ~clk;

    // One clock of stimulus, entered and left at a falling edge. Memory returns ~addr.
    task automatic cyc(input logic a_ok, input logic rdy, input logic fl, input logic resp,
                       output logic req_o, output logic pcen_o, output logic pop_o,
                       output logic [31:0] ppc, output logic [31:0] pinst, output logic padel);
        logic        acc;
        logic [31:0] addr;
        pc           = cur_pc;
        inst_addr_ok = a_ok;
        if_ready     = rdy;
        flush        = fl;
        if (resp && bus_q.size() > 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = ~bus_q[0];
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = 32'h0;
        end
        #1;
        req_o  = inst_req;
        pcen_o = pc_en;
        pop_o  = if_valid & rdy;
        ppc    = if_pc;
        pinst  = if_inst;
        padel  = if_adel;
        acc    = inst_req & a_ok;
        addr   = inst_addr;
        @(posedge clk);
        if (inst_data_ok) bus_q.delete(0);
        if (acc) bus_q.push_back(addr);
        if (pcen_o) cur_pc = cur_pc + 32'd4;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        flush        = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        if_ready     = 1'b0;
        cur_pc       = BASE;
        pc           = BASE;
        bus_q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        flush        = 1'b0;
        inst_addr_ok = 1'b1;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        if_ready     = 1'b1;
        pc           = BASE;
        @(posedge clk);
        @(negedge clk);
        checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL reset_pc_en got=%b exp=0", pc_en); end
        checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL reset_inst_req got=%b exp=0", inst_req); end
        checks++; if (inst_addr !== BASE) begin failures++; $display("FAIL reset_inst_addr got=%h exp=%h", inst_addr, BASE); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_if_pc got=%h exp=0", if_pc); end
        checks++; if (if_inst !== 32'h0) begin failures++; $display("FAIL reset_if_inst got=%h exp=0", if_inst); end
        checks++; if (if_adel !== 1'b0) begin failures++; $display("FAIL reset_if_adel got=%b exp=0", if_adel); end
        checks++; if (dut.outstanding_q !== 3'd0 || dut.discard_q !== 3'd0) begin
            failures++; $display("FAIL reset_counters out=%0d disc=%0d exp=0", dut.outstanding_q, dut.discard_q);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_pc;
        int          pops;
        do_reset();
        exp_pc = BASE;
        pops   = 0;
        for (int k = 0; k < 13; k++) begin
            cyc((k < 10), 1'b1, 1'b0, 1'b1, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
            if (k < 10) begin
                checks++; if (o_req !== 1'b1) begin failures++; $display("FAIL stream_req k=%0d got=%b exp=1", k, o_req); end
                checks++; if (o_pop !== (k >= 2)) begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, o_pop, (k >= 2)); end
            end
            if (o_pop) begin
                checks++;
                if (o_pc !== exp_pc || o_inst !== ~exp_pc || o_adel !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_head k=%0d got pc=%h inst=%h exp pc=%h inst=%h", k, o_pc, o_inst, exp_pc, ~exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        checks++; if (pops != 10) begin failures++; $display("FAIL stream_count got=%0d exp=10", pops); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL stream_drained got=%b exp=0", if_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        int          acc_n;
        int          pop_n;
        do_reset();
        acc_n = 0;
        pop_n = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
            if (o_req) acc_n++;
            checks++; if (o_req !== (k < 4)) begin failures++; $display("FAIL bp_req k=%0d got=%b exp=%b", k, o_req, (k < 4)); end
        end
        checks++; if (acc_n != 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", acc_n); end
        checks++; if (if_valid !== 1'b1 || if_pc !== BASE) begin
            failures++; $display("FAIL bp_head got valid=%b pc=%h exp valid=1 pc=%h", if_valid, if_pc, BASE);
        end
        exp_pc = BASE;
        for (int k = 0; k < 22; k++) begin
            cyc((k < 16), 1'b1, 1'b0, 1'b1, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
            if (k == 0) begin
                checks++; if (o_req !== 1'b0) begin failures++; $display("FAIL bp_release_req0 got=%b exp=0", o_req); end
            end
            if (k == 1) begin
                checks++; if (o_req !== 1'b1) begin failures++; $display("FAIL bp_release_req1 got=%b exp=1", o_req); end
            end
            if (o_req && k < 16) acc_n++;
            if (o_pop) begin
                checks++;
                if (o_pc !== exp_pc || o_inst !== ~exp_pc) begin
                    failures++;
                    $display("FAIL bp_order k=%0d got pc=%h inst=%h exp pc=%h", k, o_pc, o_inst, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                pop_n++;
            end
            checks++; if (acc_n - pop_n > 4) begin failures++; $display("FAIL bp_credit k=%0d inflight=%0d exp<=4", k, acc_n - pop_n); end
        end
        checks++; if (pop_n != acc_n || pop_n < 12) begin
            failures++; $display("FAIL bp_no_loss popped=%0d accepted=%0d exp equal and >=12", pop_n, acc_n);
        end
    endtask

    task automatic test_flush();
        int pop_n;
        do_reset();
        pop_n = 0;
        for (int k = 0; k < 2; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
        checks++; if (o_req !== 1'b0 || o_pcen !== 1'b0) begin
            failures++; $display("FAIL flush_gate got req=%b pc_en=%b exp 0 0", o_req, o_pcen);
        end
        checks++; if (dut.discard_q !== 3'd2 || dut.outstanding_q !== 3'd0) begin
            failures++; $display("FAIL flush_counters got disc=%0d out=%0d exp 2 0", dut.discard_q, dut.outstanding_q);
        end
        cur_pc = 32'h8000_0100;
        cyc(1'b1, 1'b1, 1'b0, 1'b1, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
        checks++; if (o_req !== 1'b1 || o_pop !== 1'b0) begin
            failures++; $display("FAIL flush_next got req=%b valid=%b exp 1 0", o_req, o_pop);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
            if (o_pop) begin
                pop_n++;
                checks++;
                if (o_pc !== 32'h8000_0100 || o_inst !== ~32'h8000_0100) begin
                    failures++; $display("FAIL flush_delivered got pc=%h inst=%h exp pc=80000100", o_pc, o_inst);
                end
            end
        end
        checks++; if (pop_n != 1) begin failures++; $display("FAIL flush_pop_count got=%0d exp=1", pop_n); end
    endtask

    task automatic test_flush_data_ok();
        int pop_n;
        do_reset();
        pop_n = 0;
        for (int k = 0; k < 2; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
        checks++; if (dut.discard_q !== 3'd1) begin failures++; $display("FAIL fdo_discard got=%0d exp=1", dut.discard_q); end
        cur_pc = 32'h8000_0200;
        cyc(1'b1, 1'b1, 1'b0, 1'b1, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
        checks++; if (dut.discard_q !== 3'd0) begin failures++; $display("FAIL fdo_discard_drained got=%0d exp=0", dut.discard_q); end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
            if (o_pop) begin
                pop_n++;
                checks++;
                if (o_pc !== 32'h8000_0200 || o_inst !== ~32'h8000_0200) begin
                    failures++; $display("FAIL fdo_delivered got pc=%h inst=%h exp pc=80000200", o_pc, o_inst);
                end
            end
        end
        checks++; if (pop_n != 1) begin failures++; $display("FAIL fdo_pop_count got=%0d exp=1", pop_n); end
    endtask

    task automatic test_misaligned();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
        cur_pc = 32'hbfc0_0002;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
        checks++; if (o_req !== 1'b0 || o_pcen !== 1'b0) begin
            failures++; $display("FAIL mis_wait1 got req=%b pc_en=%b exp 0 0", o_req, o_pcen);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
        checks++; if (o_req !== 1'b0 || o_pcen !== 1'b0) begin
            failures++; $display("FAIL mis_wait2 got req=%b pc_en=%b exp 0 0", o_req, o_pcen);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
        checks++; if (o_req !== 1'b0 || o_pcen !== 1'b1) begin
            failures++; $display("FAIL mis_push got req=%b pc_en=%b exp 0 1", o_req, o_pcen);
        end
        cur_pc = 32'hbfc0_0010;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
        checks++; if (o_pop !== 1'b1 || o_pc !== BASE || o_inst !== ~BASE || o_adel !== 1'b0) begin
            failures++; $display("FAIL mis_first got v=%b pc=%h inst=%h adel=%b exp pc=%h adel=0", o_pop, o_pc, o_inst, o_adel, BASE);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
        checks++; if (o_pop !== 1'b1 || o_pc !== 32'hbfc0_0002 || o_inst !== 32'h0 || o_adel !== 1'b1) begin
            failures++; $display("FAIL mis_adel got v=%b pc=%h inst=%h adel=%b exp pc=bfc00002 inst=0 adel=1", o_pop, o_pc, o_inst, o_adel);
        end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL mis_empty got=%b exp=0", if_valid); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1, o_req, o_pcen, o_pop, o_pc, o_inst, o_adel);
        checks++; if (dut.entry_count !== 3'd4) begin failures++; $display("FAIL mid_full got=%0d exp=4", dut.entry_count); end
        rst = 1'b1;
        bus_q.delete();
        #1;
        checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL mid_req_in_reset got=%b exp=0", inst_req); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL mid_if_valid got=%b exp=0", if_valid); end
        checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL mid_req got=%b exp=1", inst_req); end
        checks++; if (dut.entry_count !== 3'd0 || dut.outstanding_q !== 3'd0 || dut.discard_q !== 3'd0) begin
            failures++;
            $display("FAIL mid_counters got cnt=%0d out=%0d disc=%0d exp 0 0 0", dut.entry_count, dut.outstanding_q, dut.discard_q);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_flush_data_ok();
        test_misaligned();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
